// File: rtl/approx_mult_arbiter.sv
// approx_mult_arbiter: round-robin two-stage sequencer for a shared approximate multiplier (optional APX_ERR_COMP_EN bias compensation)
module approx_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 16,
  parameter logic [31:0] COMP = 32'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  output logic [W-1:0]              mul_a,
  output logic [W-1:0]              mul_b,
  input  logic [2*W-1:0]            mul_p,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [2*W-1:0]            res_p,
  output logic                      busy
);
  localparam int IDW = $clog2(NREQ);
  logic s1_v, s2_v, acc1, adv2, any, grant;
  logic [IDW-1:0] ptr, win, s1_id, s2_id;
  logic [2*W-1:0] s2_p, p_in;
  assign adv2 = s1_v & (~s2_v | res_ready);
  assign acc1 = ~s1_v | adv2;
  always_comb begin
    any = 1'b0;
    win = '0;
    for (int k = 0; k < NREQ; k++)
      if (!any && req_valid[(int'(ptr) + k) % NREQ]) begin
        any = 1'b1;
        win = IDW'((int'(ptr) + k) % NREQ);
      end
  end
  // rst gates the grant so req_ready is low throughout reset
  assign grant = any & acc1 & ~rst;
  assign req_ready = grant ? NREQ'(1) << win : '0;
`ifdef APX_ERR_COMP_EN
  logic [2*W:0] sum;
  assign sum = {1'b0, mul_p} + {1'b0, (2*W)'(COMP)};
  assign p_in = sum[2*W] ? '1 : sum[2*W-1:0];
`else
  assign p_in = mul_p;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      ptr   <= '0;
      s1_id <= '0;
      s2_id <= '0;
      s2_p  <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      if (grant) begin
        s1_v  <= 1'b1;
        s1_id <= win;
        mul_a <= req_a[win*W +: W];
        mul_b <= req_b[win*W +: W];
        ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      end else if (adv2) begin
        s1_v <= 1'b0;
      end
      if (adv2) begin
        s2_v  <= 1'b1;
        s2_id <= s1_id;
        s2_p  <= p_in;
      end else if (res_ready) begin
        s2_v <= 1'b0;
      end
    end
  end
  assign res_valid = s2_v;
  assign res_id = s2_id;
  assign res_p = s2_p;
  assign busy = s1_v | s2_v;
endmodule

// File: tb/tb_approx_mult_arbiter.sv
// tb_approx_mult_arbiter: directed and random checks against a queue-based reference model
module tb_approx_mult_arbiter;
  localparam int NREQ = 4, W = 16, IDW = 2;
`ifdef APX_ERR_COMP_EN
  localparam logic [31:0] COMP = 32'd16;
`else
  localparam logic [31:0] COMP = 32'd0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [NREQ-1:0] req_valid, req_ready, last_er;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0] mul_a, mul_b;
  logic [2*W-1:0] mul_p, res_p;
  logic res_valid, res_ready, busy;
  logic [IDW-1:0] res_id;
  logic fen = 1'b0;
  logic [31:0] fval = '0;
  assign mul_p = fen ? fval : mul_a * mul_b;
  approx_mult_arbiter #(.NREQ(NREQ), .W(W), .COMP(COMP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_p(res_p), .busy(busy));
  typedef struct {int id; logic [31:0] p; int t;} item_t;
  item_t q[$];
  int mptr, cyc, total, bad, npop;
  logic [31:0] held_p, p_tmp;
  int pops0;
  function automatic logic [31:0] model_p(logic [15:0] a, logic [15:0] b);
    logic [32:0] s;
    s = fen ? {1'b0, fval} : {1'b0, 32'(a) * 32'(b)};
`ifdef APX_ERR_COMP_EN
    s = s + {1'b0, COMP};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
    return s[31:0];
`endif
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one clock cycle: entered just after a negedge with inputs applied, leaves at the next negedge
  task automatic step();
    int w;
    logic [NREQ-1:0] er;
    logic erv;
    #1;
    w = -1;
    if (q.size() < 2 || res_ready)
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req_valid[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", req_ready, er);
    erv = q.size() > 0 && cyc >= q[0].t + 2;
    chk("res_valid", res_valid, erv);
    if (erv) begin
      chk("res_id", res_id, q[0].id);
      chk("res_p", res_p, q[0].p);
    end
    chk("busy", busy, q.size() > 0);
    if (erv && res_ready) begin
      void'(q.pop_front());
      npop++;
    end
    if (w >= 0) begin
      q.push_back(item_t'{w, model_p(req_a[w*W +: W], req_b[w*W +: W]), cyc});
      mptr = (w + 1) % NREQ;
    end
    last_er = er;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    mptr = 0;
  endtask
  function automatic logic [15:0] rnd16();
    int r;
    r = $urandom % 8;
    return r == 0 ? 16'h0000 : r == 1 ? 16'hFFFF : 16'($urandom);
  endfunction
  task automatic one_shot(input logic [15:0] a, input logic [15:0] b, output logic [31:0] p);
    req_valid = 4'b0001;
    req_a[0 +: W] = a;
    req_b[0 +: W] = b;
    res_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    p = res_p;
    step();
  endtask
  initial begin
    total = 0; bad = 0; npop = 0; cyc = 0; mptr = 0; last_er = '0;
    req_valid = '1; req_a = '0; req_b = '0; res_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_res_p", res_p, 0);
    chk("rst_res_id", res_id, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0100;
    req_a[2*W +: W] = 16'h0003;
    req_b[2*W +: W] = 16'h0005;
    #1;
    chk("single_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    chk("single_mul_a", mul_a, 16'h0003);
    chk("single_mul_b", mul_b, 16'h0005);
    step();
    chk("single_valid", res_valid, 1);
    chk("single_id", res_id, 2);
    chk("single_p", res_p, 32'h0000_000F + COMP);
    step();
    chk("single_idle", busy, 0);
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 16'(i + 1) * 16'h1111;
      req_b[i*W +: W] = 16'(i + 7);
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_seq", req_ready, 4'b0001 << (k % 4));
      step();
    end
    req_valid = '0;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      req_a[i*W +: W] = 16'(i + 2);
      req_b[i*W +: W] = 16'(i + 3);
    end
    req_valid = 4'b0111;
    res_ready = 1'b0;
    held_p = model_p(16'd2, 16'd3);
    for (int k = 0; k < 5; k++) begin
      if (k >= 2) begin
        #1;
        chk("bp_ready", req_ready, 0);
        chk("bp_hold_p", res_p, held_p);
        chk("bp_hold_id", res_id, 0);
      end
      step();
      req_valid = req_valid & ~last_er;
    end
    pops0 = npop;
    res_ready = 1'b1;
    repeat (5) begin
      step();
      req_valid = req_valid & ~last_er;
    end
    chk("bp_all_out", npop - pops0, 3);
    req_valid = '1;
    res_ready = 1'b0;
    step();
    step();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    mptr = 0;
    res_ready = 1'b1;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    repeat (3) step();
`ifdef APX_ERR_COMP_EN
    one_shot(16'h0004, 16'h0004, p_tmp);
    chk("comp_small", p_tmp, 32'h0000_0020);
    one_shot(16'hFFFF, 16'hFFFF, p_tmp);
    chk("comp_max", p_tmp, 32'hFFFE_0011);
    fen = 1'b1;
    fval = 32'hFFFF_FFF8;
    one_shot(16'h0001, 16'h0001, p_tmp);
    chk("comp_sat", p_tmp, 32'hFFFF_FFFF);
    fen = 1'b0;
`else
    one_shot(16'h0004, 16'h0004, p_tmp);
    chk("plain_small", p_tmp, 32'h0000_0010);
    one_shot(16'hFFFF, 16'hFFFF, p_tmp);
    chk("plain_max", p_tmp, 32'hFFFE_0001);
`endif
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!(req_valid[i] && !last_er[i])) begin
          req_valid[i] = ($urandom % 3) != 0;
          req_a[i*W +: W] = rnd16();
          req_b[i*W +: W] = rnd16();
        end
      res_ready = ($urandom % 4) != 0;
      step();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (4) step();
    chk("drain_busy", busy, 0);
    chk("drain_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
